// File: rtl/period_gen.sv
// period_gen: programmable 50%-duty square-wave generator, continuous or burst.
// in: clk rst(sync,low) en burst_start burst_len load half_period; out: test edge_strb busy period_cnt cfg_err
module period_gen #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 10,
  parameter int PCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              burst_start,
  input  logic [PCNT_W-1:0] burst_len,
  input  logic              load,
  input  logic [CNT_W-1:0]  half_period,
  output logic              test,
  output logic              edge_strb,
  output logic              busy,
  output logic [PCNT_W-1:0] period_cnt,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BURST
  } state_t;

  localparam logic [CNT_W-1:0]  C1  = CNT_W'(1);
  localparam logic [PCNT_W-1:0] P1  = PCNT_W'(1);
  localparam logic [CNT_W-1:0]  DEF = CNT_W'(DEFAULT_HALF);

  state_t            state, state_n;
  logic [CNT_W-1:0]  shadow, shadow_n;
  logic [CNT_W-1:0]  active, active_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [PCNT_W-1:0] remaining, rem_n;
  logic [PCNT_W-1:0] pcnt_n;
  logic              test_n, edge_n, cfg_n, busy_n;
  logic              start;

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    active_n = active;
    cnt_n    = cnt;
    rem_n    = remaining;
    pcnt_n   = period_cnt;
    test_n   = test;
    edge_n   = 1'b0;
    cfg_n    = 1'b0;
    start    = 1'b0;

    if (load) begin
      if (half_period != '0) shadow_n = half_period;
      else                   cfg_n    = 1'b1;
    end

    unique case (state)
      IDLE: begin
        test_n = 1'b0;
        if (burst_start) begin
          if (burst_len != '0) begin
            rem_n   = burst_len - P1;
            start   = 1'b1;
            state_n = BURST;
          end else begin
            cfg_n = 1'b1;
          end
        end else if (en) begin
          start   = 1'b1;
          state_n = RUN;
        end
      end
      RUN, BURST: begin
        if (cnt != '0) begin
          cnt_n = cnt - C1;
        end else if (test) begin
          test_n = 1'b0;
          cnt_n  = active - C1;
        end else if (state == RUN) begin
          // period end: en is only looked at here
          if (en) start   = 1'b1;
          else    state_n = IDLE;
        end else if (remaining != '0) begin
          rem_n = remaining - P1;
          start = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // shadow is sampled pre-edge, so a same-cycle load waits a period
    if (start) begin
      active_n = shadow;
      cnt_n    = shadow - C1;
      test_n   = 1'b1;
      edge_n   = 1'b1;
      pcnt_n   = period_cnt + P1;
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      shadow     <= DEF;
      active     <= DEF;
      cnt        <= '0;
      remaining  <= '0;
      period_cnt <= '0;
      test       <= 1'b0;
      edge_strb  <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      shadow     <= shadow_n;
      active     <= active_n;
      cnt        <= cnt_n;
      remaining  <= rem_n;
      period_cnt <= pcnt_n;
      test       <= test_n;
      edge_strb  <= edge_n;
      busy       <= busy_n;
      cfg_err    <= cfg_n;
    end
  end

endmodule

// File: tb/tb_period_gen.sv
// tb_period_gen: scoreboard/table bench for period_gen.
// Main instance uses defaults; a narrow instance covers wrap and max half-period.
module tb_period_gen;

  typedef struct packed {
    logic        t;
    logic        e;
    logic        b;
    logic        c;
    logic [15:0] pc;
  } exp_t;

  typedef struct {
    logic        en;
    logic        bs;
    logic [15:0] bl;
    logic        ld;
    logic [15:0] hp;
    logic        b;
    logic        c;
  } vec_t;

  logic        clk, rst;
  logic        en, bs, ld;
  logic [15:0] bl, hp;
  logic        test, edge_s, busy, cfg;
  logic [15:0] pcnt;

  logic        w_en, w_ld;
  logic [3:0]  w_hp;
  logic        w_test, w_edge, w_busy, w_cfg;
  logic [3:0]  w_pcnt;

  exp_t        sb[$];
  vec_t        vt[6];
  logic [15:0] pc_exp;
  int          n_cmp, n_bad;

  period_gen u_d (
    .clk(clk), .rst(rst), .en(en),
    .burst_start(bs), .burst_len(bl),
    .load(ld), .half_period(hp),
    .test(test), .edge_strb(edge_s), .busy(busy),
    .period_cnt(pcnt), .cfg_err(cfg)
  );

  period_gen #(.CNT_W(4), .DEFAULT_HALF(1), .PCNT_W(4)) u_w (
    .clk(clk), .rst(rst), .en(w_en),
    .burst_start(1'b0), .burst_len(4'd0),
    .load(w_ld), .half_period(w_hp),
    .test(w_test), .edge_strb(w_edge), .busy(w_busy),
    .period_cnt(w_pcnt), .cfg_err(w_cfg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t,e,b,c,pc)", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input logic t, e, b, c,
                              input logic [15:0] pc);
    return {t, e, b, c, pc};
  endfunction

  task automatic step(input logic en_i, bs_i, input logic [15:0] bl_i,
                      input logic ld_i, input logic [15:0] hp_i,
                      input exp_t x, input string nm);
    exp_t got;
    en = en_i; bs = bs_i; bl = bl_i; ld = ld_i; hp = hp_i;
    sb.push_back(x);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    cmp(nm, {12'd0, test, edge_s, busy, cfg, pcnt}, {12'd0, got});
    en = 1'b0; bs = 1'b0; ld = 1'b0;
  endtask

  // one full period of half-period h; index 0 is the rising edge
  task automatic run_period(input int h, input logic en0, en_rest, bs0,
                            input logic [15:0] bl_i, input int ld_at,
                            input logic [15:0] hp_i, input string nm);
    for (int i = 0; i < 2 * h; i++) begin
      if (i == 0) pc_exp++;
      step(i == 0 ? en0 : en_rest, i == 0 ? bs0 : 1'b0,
           i == 0 ? bl_i : 16'd0, i == ld_at, hp_i,
           mk(i < h, i == 0, 1'b1, i == ld_at && hp_i == 16'd0, pc_exp),
           nm);
    end
  endtask

  task automatic wstep(input logic en_i, ld_i, input logic [3:0] hp_i,
                       input logic [7:0] req, input string nm);
    w_en = en_i; w_ld = ld_i; w_hp = hp_i;
    @(posedge clk);
    #1;
    cmp(nm, {24'd0, w_test, w_edge, w_busy, w_cfg, w_pcnt}, {24'd0, req});
    w_ld = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; pc_exp = '0;
    rst = 1'b0; en = 1'b0; bs = 1'b0; bl = '0; ld = 1'b0; hp = '0;
    w_en = 1'b0; w_ld = 1'b0; w_hp = '0;

    vt[0] = '{en:0, bs:1, bl:0, ld:0, hp:0, b:0, c:1};
    vt[1] = '{en:0, bs:0, bl:0, ld:0, hp:0, b:0, c:0};
    vt[2] = '{en:0, bs:0, bl:0, ld:1, hp:0, b:0, c:1};
    vt[3] = '{en:0, bs:0, bl:0, ld:1, hp:2, b:0, c:0};
    vt[4] = '{en:0, bs:1, bl:0, ld:1, hp:0, b:0, c:1};
    vt[5] = '{en:0, bs:0, bl:0, ld:0, hp:0, b:0, c:0};

    step(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0), "reset0");
    step(1, 1, 4, 0, 0, mk(0, 0, 0, 0, 0), "reset1");
    rst = 1'b1;

    run_period(10, 1, 1, 0, 0, -1, 0, "default_p1");
    run_period(10, 1, 1, 0, 0, -1, 0, "default_p2");
    run_period(10, 1, 1, 0, 0, 3, 3, "load_bound");
    run_period(3, 1, 1, 0, 0, -1, 0, "h3_p1");
    run_period(3, 1, 1, 0, 0, 1, 10, "h3_p2");
    run_period(10, 1, 1, 0, 0, 4, 0, "bad_load");
    run_period(10, 1, 0, 0, 0, -1, 0, "stop_mid");
    step(0, 0, 0, 0, 0, mk(0, 0, 0, 0, pc_exp), "stop_idle");

    for (int k = 0; k < 6; k++)
      step(vt[k].en, vt[k].bs, vt[k].bl, vt[k].ld, vt[k].hp,
           mk(1'b0, 1'b0, vt[k].b, vt[k].c, pc_exp), $sformatf("idle_vec%0d", k));

    run_period(2, 1, 1, 1, 4, -1, 0, "burst_p1");
    run_period(2, 1, 1, 0, 0, -1, 0, "burst_p2");
    run_period(2, 1, 1, 1, 0, -1, 0, "burst_p3");
    run_period(2, 1, 1, 0, 0, -1, 0, "burst_p4");
    step(1, 0, 0, 0, 0, mk(0, 0, 0, 0, pc_exp), "burst_end");
    step(0, 0, 0, 1, 1, mk(0, 0, 0, 0, pc_exp), "burst_idle");

    run_period(1, 1, 1, 0, 0, -1, 0, "h1_p1");
    run_period(1, 1, 1, 0, 0, -1, 0, "h1_p2");
    run_period(1, 1, 0, 0, 0, -1, 0, "h1_last");
    step(0, 0, 0, 0, 0, mk(0, 0, 0, 0, pc_exp), "h1_stop");

    run_period(1, 1, 1, 1, 3, -1, 0, "rb_p1");
    run_period(1, 0, 0, 0, 0, -1, 0, "rb_p2");
    pc_exp++;
    step(0, 0, 0, 0, 0, mk(1, 1, 1, 0, pc_exp), "rb_p3");
    rst = 1'b0;
    pc_exp = '0;
    step(1, 0, 0, 0, 0, mk(0, 0, 0, 0, 0), "rst_mid");
    rst = 1'b1;
    step(0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0), "post_rst");
    run_period(10, 1, 1, 0, 0, -1, 0, "def_again");
    run_period(10, 1, 0, 0, 0, -1, 0, "def_stop");
    step(0, 0, 0, 0, 0, mk(0, 0, 0, 0, pc_exp), "def_idle");

    for (int i = 0; i < 32; i++)
      wstep(1, 0, 0, {i % 2 == 0, i % 2 == 0, 1'b1, 1'b0, 4'((i / 2) + 1)},
            "wrap");
    wstep(0, 0, 0, 8'h00, "w_stop");
    wstep(0, 1, 15, 8'h00, "w_load15");
    for (int j = 0; j < 30; j++)
      wstep(1, 0, 0, {j < 15, j == 0, 1'b1, 1'b0, 4'd1}, "w_max_half");
    wstep(0, 0, 0, 8'h01, "w_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/period_gen.md
Name: period_gen

Overview:
- Programmable square-wave generator; the transmit-side counterpart of the frequency/period detector.
- Drives a periodic test signal whose half-period is a whole number of reference-clock cycles.
- Supports continuous mode and fixed-length burst mode.
- Period changes take effect only at period boundaries, so the output never glitches; used to stimulate and calibrate the detector in-system.

Parameters:
- CNT_W, 16, width of the half-period counter and of half_period.
- DEFAULT_HALF, 10, half-period (in clk cycles) loaded at reset.
- PCNT_W, 16, width of period_cnt and burst_len.

Ports:
- clk  in  1  reference clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  level; 1 = run continuously, 0 = stop gracefully.
- burst_start  in  1  one-cycle strobe; start a burst of burst_len periods.
- burst_len  in  PCNT_W  number of full periods per burst.
- load  in  1  one-cycle strobe; capture half_period into the shadow register.
- half_period  in  CNT_W  requested half-period in clk cycles; must be >= 1.
- test  out  1  generated square wave.
- edge_strb  out  1  one-cycle pulse coincident with every rising edge of test.
- busy  out  1  1 whenever state != IDLE.
- period_cnt  out  PCNT_W  count of rising edges generated since reset; wraps modulo 2^PCNT_W.
- cfg_err  out  1  one-cycle pulse when a load or burst request is rejected.

Behaviour:
- Reset (rst=0 at an edge):
  - test=0, edge_strb=0, busy=0, cfg_err=0, period_cnt=0, state=IDLE.
  - shadow=DEFAULT_HALF, active=DEFAULT_HALF, cnt=0, remaining=0.
  - Reset mid-operation aborts immediately; test is 0 after that edge.
- Registers:
  - shadow: written by load.
  - active: half-period in use.
  - cnt: down-counter of width CNT_W.
  - remaining: burst period counter of width PCNT_W.
- Load:
  - load=1 with half_period>=1: shadow<=half_period.
  - load=1 with half_period==0: shadow unchanged, cfg_err=1 on the next cycle.
  - Accepted in any state.
- Start of period (every rising edge of test, including the first):
  - Same edge: active<=shadow (value registered before this edge), cnt<=shadow-1, test<=1, edge_strb<=1, period_cnt<=period_cnt+1.
  - A load in the same cycle as a rising edge applies to the following period.
- Counting:
  - Otherwise, if cnt!=0: cnt<=cnt-1.
  - If cnt==0 and test=1: falling edge; test<=0, cnt<=active-1.
  - If cnt==0 and test=0: period end; see the state rules below.
- Resulting waveform: high for active cycles, low for active cycles, period = 2*active clk cycles, 50% duty.
  - active=1 gives test toggling every clk.
  - First rising edge occurs on the same edge the start request is sampled.
- State IDLE:
  - test=0.
  - burst_start=1 and burst_len!=0: remaining<=burst_len-1, start of period, go to BURST.
  - burst_start=1 and burst_len==0: stay in IDLE, cfg_err pulse.
  - else en=1: start of period, go to RUN.
  - burst_start has priority over en.
- State RUN:
  - At period end: en=1 starts the next period; en=0 goes to IDLE with test=0.
  - The stop is graceful: deasserting en never truncates a period.
  - burst_start is ignored.
- State BURST:
  - At period end: remaining!=0 gives remaining<=remaining-1 and a new period; remaining==0 goes to IDLE.
  - en and burst_start are ignored until IDLE.
  - Exactly burst_len rising edges are produced.
- busy is registered with state: 1 from the start edge through the final period end; 0 in IDLE.
- Width rules:
  - half_period = 2^CNT_W-1 is legal.
  - period_cnt wraps to 0 after 2^PCNT_W-1.

Test Plan:
- Reset default: rst=0 for 2 cycles, then en=1 → test high 10 cycles, low 10 cycles, repeating; edge_strb every 20 cycles; period_cnt=1 after the first edge.
- Load at boundary: running with H=10, load half_period=3 mid-high-phase → current period completes as 10/10; next period is 3/3 (period 6); no short pulse.
- Invalid load: load half_period=0 → cfg_err one pulse, period unchanged at 20; burst_start with burst_len=0 in IDLE → cfg_err, busy stays 0.
- Burst: H=2, burst_len=4, burst_start → exactly 4 rising edges, 16 cycles busy, then IDLE with test=0; period_cnt +4; en=1 during the burst is ignored.
- Graceful stop and minimum period: H=1, en=1 → test toggles every clk; drop en while test=1 → one more low cycle, then IDLE; drop en in the middle of an H=10 period → full period completes.
- Reset mid-burst, plus wrap: assert rst in the middle of a burst → test=0, busy=0, period_cnt=0 after that edge. Preset by running 65535 edges, then one more → period_cnt=0.
